// File: rtl/multi_mod_seq_counter_if.sv
// Bus bundle for the multi-modulus sequence counter: control, live moduli and
// the registered/combinational status the sequencer publishes.
interface multi_mod_seq_counter_if #(
    parameter int WIDTH     = 3,
    parameter int NUM_MODES = 2
);
    localparam int MODE_W = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;

    logic                       en;
    logic                       sclr;
    logic [NUM_MODES*WIDTH-1:0] term_cfg;
    logic [WIDTH-1:0]           count;
    logic [MODE_W-1:0]          mode;
    logic                       tc;
    logic                       seq_last;
    logic                       seq_done;

    modport master (
        output en, sclr, term_cfg,
        input  count, mode, tc, seq_last, seq_done
    );

    modport slave (
        input  en, sclr, term_cfg,
        output count, mode, tc, seq_last, seq_done
    );
endinterface

// File: rtl/multi_mod_seq_counter.sv
// Multi-modulus frame/slot sequencer: counts 0..term[mode], wraps, steps to the
// next mode and pulses seq_done one cycle after the last mode wraps.
module multi_mod_seq_counter #(
    parameter int WIDTH     = 3,
    parameter int NUM_MODES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    multi_mod_seq_counter_if.slave  bus
);
    localparam int                MODE_W     = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
    localparam logic [MODE_W-1:0] LAST_MODE  = MODE_W'(NUM_MODES - 1);
    localparam logic [MODE_W:0]   MODE_LIMIT = (MODE_W + 1)'(NUM_MODES);

    logic [WIDTH-1:0]  count_q;
    logic [WIDTH-1:0]  count_d;
    logic [MODE_W-1:0] mode_q;
    logic [MODE_W-1:0] mode_d;
    logic              seq_done_q;
    logic              seq_done_d;
    logic [WIDTH-1:0]  term_s;
    logic              tc_s;
    logic              last_mode_s;

    // Terminal-count mux; an undecodable mode index falls back to mode 0's term
    always_comb begin
        term_s = bus.term_cfg[WIDTH-1:0];
        if ({1'b0, mode_q} < MODE_LIMIT) begin
            term_s = bus.term_cfg[int'(mode_q)*WIDTH +: WIDTH];
        end else begin
            term_s = bus.term_cfg[WIDTH-1:0];
        end
    end

    // >= so a term lowered below the running count wraps instead of rolling over
    assign tc_s        = (count_q >= term_s);
    assign last_mode_s = (mode_q == LAST_MODE);

    // Next-state: clear beats enable beats hold; seq_done is never stretched
    always_comb begin
        count_d    = count_q;
        mode_d     = mode_q;
        seq_done_d = 1'b0;
        if (bus.sclr) begin
            count_d = {WIDTH{1'b0}};
            mode_d  = {MODE_W{1'b0}};
        end else if (bus.en) begin
            if (tc_s) begin
                count_d = {WIDTH{1'b0}};
                if (mode_q >= LAST_MODE) begin
                    mode_d     = {MODE_W{1'b0}};
                    seq_done_d = last_mode_s;
                end else begin
                    mode_d     = mode_q + MODE_W'(1);
                    seq_done_d = 1'b0;
                end
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end else begin
            count_d = count_q;
            mode_d  = mode_q;
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q    <= {WIDTH{1'b0}};
            mode_q     <= {MODE_W{1'b0}};
            seq_done_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            mode_q     <= mode_d;
            seq_done_q <= seq_done_d;
        end
    end

    assign bus.count    = count_q;
    assign bus.mode     = mode_q;
    assign bus.seq_done = seq_done_q;
    assign bus.tc       = tc_s;
    assign bus.seq_last = tc_s & last_mode_s;
endmodule

// File: tb/tb_multi_mod_seq_counter.sv
// Directed bench: default 2-mode counter plus a 4-bit 3-mode instance, checked
// against hand-derived sequences.
module tb_multi_mod_seq_counter;
    logic clk;
    logic rst_a;
    logic rst_b;
    int   checks;
    int   errors;

    multi_mod_seq_counter_if #(.WIDTH(3), .NUM_MODES(2)) ifa ();
    multi_mod_seq_counter_if #(.WIDTH(4), .NUM_MODES(3)) ifb ();

    multi_mod_seq_counter #(.WIDTH(3), .NUM_MODES(2)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ifa)
    );

    multi_mod_seq_counter #(.WIDTH(4), .NUM_MODES(3)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected states after each edge of the first two periods (terms 3 then 4)
    int exp_cnt  [18] = '{1,2,3,0,1,2,3,4,0, 1,2,3,0,1,2,3,4,0};
    int exp_mode [18] = '{0,0,0,1,1,1,1,1,0, 0,0,0,1,1,1,1,1,0};
    int exp_tc   [18] = '{0,0,1,0,0,0,0,1,0, 0,0,1,0,0,0,0,1,0};
    int exp_last [18] = '{0,0,0,0,0,0,0,1,0, 0,0,0,0,0,0,0,1,0};
    int exp_done [18] = '{0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0,0,1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input int c, input int m, input int t,
                         input int l, input int d);
        chk({tag, ".count"},    32'(ifa.count),    32'(c));
        chk({tag, ".mode"},     32'(ifa.mode),     32'(m));
        chk({tag, ".tc"},       32'(ifa.tc),       32'(t));
        chk({tag, ".seq_last"}, 32'(ifa.seq_last), 32'(l));
        chk({tag, ".seq_done"}, 32'(ifa.seq_done), 32'(d));
    endtask

    task automatic chk_b(input string tag, input int c, input int m, input int t,
                         input int l, input int d);
        chk({tag, ".count"},    32'(ifb.count),    32'(c));
        chk({tag, ".mode"},     32'(ifb.mode),     32'(m));
        chk({tag, ".tc"},       32'(ifb.tc),       32'(t));
        chk({tag, ".seq_last"}, 32'(ifb.seq_last), 32'(l));
        chk({tag, ".seq_done"}, 32'(ifb.seq_done), 32'(d));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_a        = 1'b0;
        rst_b        = 1'b0;
        ifa.en       = 1'b0;
        ifa.sclr     = 1'b0;
        ifa.term_cfg = {3'd4, 3'd3};
        ifb.en       = 1'b0;
        ifb.sclr     = 1'b0;
        ifb.term_cfg = {4'd0, 4'd15, 4'd5};

        // 1: reset state, then two full periods
        #12;
        chk_a("reset_a", 0, 0, 0, 0, 0);
        rst_a  = 1'b1;
        ifa.en = 1'b1;
        for (int i = 0; i < 18; i++) begin
            tick();
            chk_a($sformatf("t1_%0d", i), exp_cnt[i], exp_mode[i], exp_tc[i],
                  exp_last[i], exp_done[i]);
        end

        // 2: enable low for three cycles at count=2 mode=1
        repeat (6) tick();
        chk_a("t2_pre", 2, 1, 0, 0, 0);
        ifa.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_a($sformatf("t2_hold%0d", i), 2, 1, 0, 0, 0);
        end
        ifa.en = 1'b1;
        tick();
        chk_a("t2_r3", 3, 1, 0, 0, 0);
        tick();
        chk_a("t2_r4", 4, 1, 1, 1, 0);
        tick();
        chk_a("t2_wrap", 0, 0, 0, 0, 1);

        // 3: sync clear at count=3 mode=1, then clear together with reset
        repeat (7) tick();
        chk_a("t3_pre", 3, 1, 0, 0, 0);
        ifa.sclr = 1'b1;
        tick();
        chk_a("t3_sclr", 0, 0, 0, 0, 0);
        ifa.sclr = 1'b0;
        repeat (2) tick();
        chk_a("t3_run", 2, 0, 0, 0, 0);
        rst_a    = 1'b0;
        ifa.sclr = 1'b1;
        #1;
        chk_a("t3_both_async", 0, 0, 0, 0, 0);
        tick();
        chk_a("t3_both_edge", 0, 0, 0, 0, 0);
        #3;
        rst_a = 1'b1;
        tick();
        chk_a("t3_sclr_only", 0, 0, 0, 0, 0);
        ifa.sclr = 1'b0;
        tick();
        chk_a("t3_resume", 1, 0, 0, 0, 0);

        // 4: asynchronous reset mid-cycle at count=4 mode=1
        repeat (7) tick();
        chk_a("t4_pre", 4, 1, 1, 1, 0);
        #3;
        rst_a = 1'b0;
        #1;
        chk_a("t4_async", 0, 0, 0, 0, 0);
        #2;
        rst_a = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk_a($sformatf("t4_restart%0d", i), i, 0, (i == 3) ? 1 : 0, 0, 0);
        end

        // 6: lower mode-1 term below the running count
        repeat (4) tick();
        chk_a("t6_pre", 3, 1, 0, 0, 0);
        ifa.term_cfg = {3'd1, 3'd3};
        #1;
        chk_a("t6_live", 3, 1, 1, 1, 0);
        tick();
        chk_a("t6_wrap", 0, 0, 0, 0, 1);
        ifa.term_cfg = {3'd4, 3'd3};

        // 5: 4-bit, 3 modes, terms {0,15,5}: period 23
        chk_b("reset_b", 0, 0, 0, 0, 0);
        rst_b  = 1'b1;
        ifb.en = 1'b1;
        for (int k = 1; k <= 46; k++) begin
            int p;
            int c;
            int m;
            p = k % 23;
            if (p < 6) begin
                m = 0;
                c = p;
            end else if (p < 22) begin
                m = 1;
                c = p - 6;
            end else begin
                m = 2;
                c = 0;
            end
            tick();
            chk_b($sformatf("t5_%0d", k), c, m,
                  ((m == 0 && c == 5) || (m == 1 && c == 15) || m == 2) ? 1 : 0,
                  (m == 2) ? 1 : 0, (p == 0) ? 1 : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
